spi_miso_rx_fifo: RTL
=====================

Name: spi_miso_rx_fifo

Overview:
Parametrised SPI slave receive path: deserialises spi_miso_in into DSIZE-bit words while spi_cs is low and queues them in an internal word FIFO. The consumer drains the FIFO with a data_av/read_req handshake. It is the successor to the fixed 8-bit single-buffer receiver, adding the following:
- configurable bit order
- frame-abort handling
- multi-word buffering
- overflow reporting

Parameters:
DSIZE, 8, data bits per word (>=2)
FIFO_DEPTH, 4, word FIFO depth (power of 2, >=2)
MSB_FIRST, 1, 1 = first serial bit lands in bit DSIZE-1; 0 = first bit lands in bit 0

Ports:
spi_clk  input  1  single clock; serial clock, rising edge, free-running (also runs while spi_cs high)
spi_rst  input  1  synchronous, active-high reset
spi_cs  input  1  chip select, active low
spi_miso_in  input  1  serial data, sampled on rising spi_clk
read_req  input  1  consumer pop request
spi_miso_out  output  DSIZE  FIFO head word; 0 when data_av=0
data_av  output  1  FIFO not empty
fifo_full  output  1  FIFO holds FIFO_DEPTH words
level  output  $clog2(FIFO_DEPTH)+1  words held
overflow  output  1  sticky; a completed word was dropped
frame_abort  output  1  one-cycle pulse; partial word discarded
parity_err  output  1  sticky parity error (0 when feature compiled out)

Behaviour:
- Reset (spi_rst=1 at rising edge):
  - bit counter, shift register, FIFO pointers, overflow, parity_err and frame_abort all go to 0.
  - spi_miso_out=0, data_av=0, level=0.
  - Reset mid-frame discards the partial word; reset wins over every other event on that edge.
- Shift stage, spi_cs=0, each edge:
  - MSB_FIRST=1: shreg <= {shreg[DSIZE-2:0], spi_miso_in}.
  - MSB_FIRST=0: shreg <= {spi_miso_in, shreg[DSIZE-1:1]}.
  - bit_cnt increments.
- Word completion:
  - The edge sampling bit index DSIZE-1 forms the word including the current bit and pushes it into the FIFO on that same edge.
  - bit_cnt wraps to 0; back-to-back words in one frame need no idle bit.
- Latency: if the FIFO was empty, data_av=1 and spi_miso_out=word immediately after the completing edge.
- Frame abort: on an edge with spi_cs=1 and bit_cnt!=0:
  - shreg content is discarded and bit_cnt <= 0.
  - frame_abort=1 for exactly that one cycle.
  - spi_cs=1 with bit_cnt=0 takes no action.
- FIFO: first-word-fall-through.
  - Pop happens on an edge with read_req=1 and data_av=1.
  - read_req while empty is ignored.
- Push with FIFO full:
  - Push and pop on the same edge: both occur, level unchanged, no overflow.
  - Push with no pop: word dropped, FIFO content unchanged, overflow <= 1 (sticky until reset).
- Status outputs:
  - level counts 0..FIFO_DEPTH.
  - fifo_full = (level==FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
SPI_RX_PARITY_EN:
- Defined:
  - Each word is DSIZE data bits followed by one even-parity bit, so the frame unit is DSIZE+1 bits.
  - The word is pushed on the parity-bit edge.
  - If XOR(data, parity)!=0, the word is still pushed and parity_err <= 1 (sticky).
  - Abort rule applies to any bit_cnt!=0 including the parity position.
- Undefined: DSIZE bits per word; parity_err tied 0.

Decomposition:
- Package spi_rx_pkg: bit-counter width function, level width constant (CLOG2 of FIFO_DEPTH plus 1), MSB_FIRST encoding constants.
- One natural sub-module, spi_rx_word_fifo: synchronous FWFT FIFO (push/pop/full/empty/level) parametrised by DSIZE and FIFO_DEPTH.
- Shifter, bit counter and abort logic stay in the top.

Test Plan:
- Reset, then cs low, MSB_FIRST=1, serial 1,0,1,0,0,1,0,1 -> after 8th edge data_av=1, spi_miso_out=8'hA5, level=1.
- Same serial bits with MSB_FIRST=0 -> spi_miso_out=8'hA5 bit-reversed = 8'hA5 mirrored = 8'hA5? Use 1,1,0,0,0,0,0,0 instead -> 8'h03 (vs 8'hC0 for MSB_FIRST=1).
- Abort and idle CS:
  - 3 bits then cs high -> frame_abort pulses 1 cycle, level stays 0.
  - Next full byte 8'h3C is received correctly.
- Overflow:
  - Stream 5 words 8'h01..8'h05, read_req=0, DEPTH=4 -> fifo_full=1, overflow=1.
  - Drain yields 01,02,03,04 in order, then data_av=0 and spi_miso_out=0.
- Full with simultaneous push and pop: FIFO full, 8th bit of next word coincides with read_req=1 -> level stays 4, overflow stays 0, order preserved.
- SPI_RX_PARITY_EN defined:
  - 8'h81 with parity 0 -> parity_err=0.
  - 8'h80 with parity 0 -> word pushed, parity_err=1.
  - spi_rst asserted mid-word -> all outputs 0 next cycle.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared constants and sizing helpers for the SPI MISO receive path.
package spi_rx_pkg;

    localparam int MSB_FIRST_ENC = 1;
    localparam int LSB_FIRST_ENC = 0;

    // Width of a counter that holds 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of an occupancy count 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_word_fifo.sv
// Synchronous first-word-fall-through word FIFO with occupancy count.
module spi_rx_word_fifo
    import spi_rx_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                spi_clk,
    input  logic                                spi_rst,
    input  logic                                push,
    input  logic [DSIZE-1:0]                    push_data,
    input  logic                                pop,
    output logic [DSIZE-1:0]                    head,
    output logic                                empty,
    output logic                                full,
    output logic [level_width(FIFO_DEPTH)-1:0]  level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = level_width(FIFO_DEPTH);

    logic [DSIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    assign empty     = (level == '0);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign pop_fire  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_fire = push && (!full || pop_fire);
    assign head      = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is not reset; a word is only visible once level says it was written.
    always_ff @(posedge spi_clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
            if (push_fire && !pop_fire) begin
                level <= level + LW'(1);
            end else if (pop_fire && !push_fire) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_miso_rx_fifo.sv
// SPI slave receive path: deserialiser, frame-abort detection and word FIFO.
// Optional even parity per word when SPI_RX_PARITY_EN is defined.
module spi_miso_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                                spi_clk,
    input  logic                                spi_rst,
    input  logic                                spi_cs,
    input  logic                                spi_miso_in,
    input  logic                                read_req,
    output logic [DSIZE-1:0]                    spi_miso_out,
    output logic                                data_av,
    output logic                                fifo_full,
    output logic [level_width(FIFO_DEPTH)-1:0]  level,
    output logic                                overflow,
    output logic                                frame_abort,
    output logic                                parity_err
);

`ifdef SPI_RX_PARITY_EN
    localparam int FRAME_BITS = DSIZE + 1;
`else
    localparam int FRAME_BITS = DSIZE;
`endif
    localparam int CNT_W = cnt_width(FRAME_BITS);

    logic [CNT_W-1:0] bit_cnt;
    logic [DSIZE-1:0] shreg;
    logic [DSIZE-1:0] shreg_next;
    logic [DSIZE-1:0] push_word;
    logic             last_bit;
    logic             shift_en;
    logic             word_push;
    logic             fifo_empty;

    assign last_bit  = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign word_push = !spi_cs && last_bit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST == MSB_FIRST_ENC) begin
            shreg_next = {shreg[DSIZE-2:0], spi_miso_in};
        end else begin
            shreg_next = {spi_miso_in, shreg[DSIZE-1:1]};
        end
    end

`ifdef SPI_RX_PARITY_EN
    // The parity bit is not shifted in; the data word is already complete.
    assign shift_en  = (bit_cnt < CNT_W'(DSIZE));
    assign push_word = shreg;

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            parity_err <= 1'b0;
        end else if (word_push && (^{shreg, spi_miso_in})) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign shift_en   = 1'b1;
    assign push_word  = shreg_next;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            if (!spi_cs) begin
                if (shift_en) shreg <= shreg_next;
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                if (word_push && fifo_full && !(read_req && data_av)) begin
                    overflow <= 1'b1;
                end
            end else if (bit_cnt != '0) begin
                bit_cnt     <= '0;
                shreg       <= '0;
                frame_abort <= 1'b1;
            end
        end
    end

    spi_rx_word_fifo #(
        .DSIZE      (DSIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .spi_clk   (spi_clk),
        .spi_rst   (spi_rst),
        .push      (word_push),
        .push_data (push_word),
        .pop       (read_req),
        .head      (spi_miso_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign data_av = !fifo_empty;

endmodule
